// File: rtl/exu_mul_pkg.sv
// Shared types and limits for the EXU pipelined multiplier.
// Tags are carried at a fixed maximum width and trimmed to TAG_W at the output.
package exu_mul_pkg;

   localparam int MUL_MIN_STAGES = 3;
   localparam int MUL_MAX_STAGES = 5;
   localparam int MUL_TAG_MAX_W  = 16;

   typedef logic [MUL_TAG_MAX_W-1:0] mul_tag_t;

   typedef struct packed {
      logic     rs1_sign;
      logic     rs2_sign;
      logic     low;
      logic     byp_rs1;
      logic     byp_rs2;
      mul_tag_t tag;
   } mul_req_t;

   typedef struct packed {
      logic     valid;
      logic     low;
      logic     hit;
      mul_tag_t tag;
   } mul_meta_t;

endpackage

// File: rtl/exu_mul_reuse_cache.sv
// Single-entry operand/product reuse cache: the tag is compared in E1 and written as a
// miss leaves E1; the product register is written as that miss leaves the last stage.
module exu_mul_reuse_cache
   import exu_mul_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic [XLEN-1:0]   opa,
   input  logic [XLEN-1:0]   opb,
   input  logic              rs1_sign,
   input  logic              rs2_sign,
   input  logic              tag_wr,
   input  logic              prod_wr,
   input  logic [2*XLEN-1:0] prod_in,
   output logic              hit,
   output logic [2*XLEN-1:0] prod
);

   logic            valid;
   logic [XLEN-1:0] tag_a;
   logic [XLEN-1:0] tag_b;
   logic            tag_s1;
   logic            tag_s2;

   // low is deliberately not part of the match: both halves come from one product
   assign hit = valid && (tag_a == opa) && (tag_b == opb) &&
                (tag_s1 == rs1_sign) && (tag_s2 == rs2_sign);

   always_ff @(posedge clk) begin
      if (rst) begin
         valid  <= 1'b0;
         tag_a  <= '0;
         tag_b  <= '0;
         tag_s1 <= 1'b0;
         tag_s2 <= 1'b0;
         prod   <= '0;
      end else begin
         if (flush) begin
            valid <= 1'b0;
         end else if (tag_wr) begin
            valid  <= 1'b1;
            tag_a  <= opa;
            tag_b  <= opb;
            tag_s1 <= rs1_sign;
            tag_s2 <= rs2_sign;
         end
         if (prod_wr) begin
            prod <= prod_in;
         end
      end
   end

endmodule

// File: rtl/exu_mul_pipe.sv
// Parametrised pipelined integer multiplier: E1 (raw op, bypass, reuse lookup),
// E2 (extended operands), then STAGES-2 product registers ending at the output.
module exu_mul_pipe
   import exu_mul_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int STAGES = 3,
   parameter int TAG_W  = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             freeze,
   input  logic             flush,
   input  logic             in_valid,
   input  logic             in_rs1_sign,
   input  logic             in_rs2_sign,
   input  logic             in_low,
   input  logic             in_byp_rs1,
   input  logic             in_byp_rs2,
   input  logic [TAG_W-1:0] in_tag,
   input  logic [XLEN-1:0]  a,
   input  logic [XLEN-1:0]  b,
   input  logic [XLEN-1:0]  lsu_result,
   output logic             out_valid,
   output logic [TAG_W-1:0] out_tag,
   output logic [XLEN-1:0]  out,
   output logic             out_reuse
);

   localparam int NP = STAGES - 2;
   localparam int XW = XLEN + 1;
   localparam int PW = 2 * XLEN;

   if (STAGES < MUL_MIN_STAGES || STAGES > MUL_MAX_STAGES) begin : g_bad_stages
      $error("exu_mul_pipe: STAGES must be within 3..5");
   end
   if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $error("exu_mul_pipe: XLEN must be 32 or 64");
   end
   if (TAG_W > MUL_TAG_MAX_W) begin : g_bad_tag
      $error("exu_mul_pipe: TAG_W exceeds MUL_TAG_MAX_W");
   end

   function automatic logic [XLEN-1:0] sel_half(input logic [PW-1:0] p, input logic low);
      return low ? p[XLEN-1:0] : p[PW-1:XLEN];
   endfunction

   logic advance;
   assign advance = !freeze;

   // ---- E1: raw op capture ----
   logic            vld_p0;
   mul_req_t        req_p0;
   logic [XLEN-1:0] a_p0;
   logic [XLEN-1:0] b_p0;

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p0 <= 1'b0;
         req_p0 <= '0;
         a_p0   <= '0;
         b_p0   <= '0;
      end else if (flush) begin
         vld_p0 <= 1'b0;
      end else if (advance) begin
         vld_p0 <= in_valid;
         if (in_valid) begin
            req_p0.rs1_sign <= in_rs1_sign;
            req_p0.rs2_sign <= in_rs2_sign;
            req_p0.low      <= in_low;
            req_p0.byp_rs1  <= in_byp_rs1;
            req_p0.byp_rs2  <= in_byp_rs2;
            req_p0.tag      <= mul_tag_t'(in_tag);
            a_p0            <= a;
            b_p0            <= b;
         end
      end
   end

   // E1 keeps re-reading lsu_result while frozen, so the unfreezing cycle's value wins
   logic [XLEN-1:0]        opa_e1;
   logic [XLEN-1:0]        opb_e1;
   logic signed [XW-1:0]   xa_e1;
   logic signed [XW-1:0]   xb_e1;
   logic                   hit_c;
   logic                   hit_e1;
   logic                   tag_wr;

   assign opa_e1 = req_p0.byp_rs1 ? lsu_result : a_p0;
   assign opb_e1 = req_p0.byp_rs2 ? lsu_result : b_p0;
   assign xa_e1  = {req_p0.rs1_sign & opa_e1[XLEN-1], opa_e1};
   assign xb_e1  = {req_p0.rs2_sign & opb_e1[XLEN-1], opb_e1};
   assign hit_e1 = vld_p0 & hit_c;
   assign tag_wr = vld_p0 & ~hit_c & advance;

   // ---- E2: extended operands ----
   mul_meta_t            meta_p1;
   logic signed [XW-1:0] xa_p1;
   logic signed [XW-1:0] xb_p1;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_p1 <= '0;
         xa_p1   <= '0;
         xb_p1   <= '0;
      end else if (flush) begin
         meta_p1.valid <= 1'b0;
      end else if (advance) begin
         meta_p1.valid <= vld_p0;
         meta_p1.low   <= req_p0.low;
         meta_p1.hit   <= hit_e1;
         meta_p1.tag   <= req_p0.tag;
         if (vld_p0 && !hit_c) begin
            xa_p1 <= xa_e1;
            xb_p1 <= xb_e1;
         end
      end
   end

   logic signed [2*XW-1:0] prod_full;
   logic [1:0]             unused_prod_hi;
   logic [PW-1:0]          prod_e2;

   assign prod_full                 = xa_p1 * xb_p1;
   assign {unused_prod_hi, prod_e2} = prod_full;

   // ---- P1..P(STAGES-2): product retiming registers ----
   for (genvar k = 0; k < NP; k++) begin : g_pstage
      mul_meta_t     meta_in;
      logic [PW-1:0] prod_in;
      mul_meta_t     meta_q;
      logic [PW-1:0] prod_q;

      if (k == 0) begin : g_from_e2
         assign meta_in = meta_p1;
         assign prod_in = prod_e2;
      end else begin : g_from_prev
         assign meta_in = g_pstage[k-1].meta_q;
         assign prod_in = g_pstage[k-1].prod_q;
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            meta_q <= '0;
            prod_q <= '0;
         end else if (flush) begin
            meta_q.valid <= 1'b0;
         end else if (advance) begin
            meta_q <= meta_in;
            prod_q <= prod_in;
         end
      end
   end

   // ---- Output: last product stage or cached product ----
   mul_meta_t     meta_l;
   logic [PW-1:0] prod_l;
   logic [PW-1:0] cache_prod;
   logic [PW-1:0] prod_sel;
   logic          prod_wr;
   mul_tag_t      unused_tag;

   assign meta_l     = g_pstage[NP-1].meta_q;
   assign prod_l     = g_pstage[NP-1].prod_q;
   assign prod_wr    = meta_l.valid & ~meta_l.hit & advance;
   assign prod_sel   = meta_l.hit ? cache_prod : prod_l;
   assign out        = sel_half(prod_sel, meta_l.low);
   assign out_valid  = meta_l.valid;
   assign out_tag    = meta_l.tag[TAG_W-1:0];
   assign out_reuse  = meta_l.valid & meta_l.hit;
   assign unused_tag = meta_l.tag;

   exu_mul_reuse_cache #(
      .XLEN(XLEN)
   ) u_cache (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .opa      (opa_e1),
      .opb      (opb_e1),
      .rs1_sign (req_p0.rs1_sign),
      .rs2_sign (req_p0.rs2_sign),
      .tag_wr   (tag_wr),
      .prod_wr  (prod_wr),
      .prod_in  (prod_l),
      .hit      (hit_c),
      .prod     (cache_prod)
   );

endmodule
